dcache_miss_ctrl: RTL and testbench

DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

---
 rtl/dcache_ctrl_pkg.sv | 14 +
 rtl/dcache_miss_ctrl_sat_counter.sv | 25 ++
 rtl/dcache_miss_ctrl.sv | 112 +++++++++++
 tb/tb_dcache_miss_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the data-cache miss controller: FSM state encoding and
// the default width of the performance counters.
package dcache_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_READMISS  = 2'd2,
        ST_REFILL    = 2'd3
    } state_e;

endpackage

// File: rtl/dcache_miss_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping, with a
// synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: stalls the pipeline on a miss, writes back a
// dirty victim, fetches the line and strobes the refill. Optional miss and
// stall-cycle counters are built when DCACHE_PERF_EN is defined.
module dcache_miss_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             hit_i,
    input  logic             dirty_i,
    input  logic             mem_ack_i,
    output logic             halt_o,
    output logic             mem_enable_o,
    output logic             mem_write_o,
    output logic             victim_sel_o,
    output logic             refill_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    state_e state;
    logic   miss;

    assign miss = (state == ST_IDLE) && req_i && !hit_i;

    // Combinational so the pipeline freezes in the very cycle the miss is seen.
    assign halt_o = (state != ST_IDLE) || (req_i && !hit_i);

    // Memory-side outputs are registered together with the state, so each
    // one is a clean decode of the state it belongs to.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: async reset drops any in-flight transaction; a late ack then
        // lands in IDLE, where it is ignored.
        if (!rst_i) begin
            state        <= ST_IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            victim_sel_o <= 1'b0;
            refill_o     <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every output sees the same
            // pre-edge state regardless of statement order.
            case (state)
                ST_IDLE: begin
                    if (miss) begin
                        mem_enable_o <= 1'b1;
                        if (dirty_i) begin
                            state        <= ST_WRITEBACK;
                            mem_write_o  <= 1'b1;
                            victim_sel_o <= 1'b1;
                        end else begin
                            state        <= ST_READMISS;
                            mem_write_o  <= 1'b0;
                            victim_sel_o <= 1'b0;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    // Enable stays high: the fetch follows the write-back ack gap-free.
                    if (mem_ack_i) begin
                        state        <= ST_READMISS;
                        mem_write_o  <= 1'b0;
                        victim_sel_o <= 1'b0;
                    end
                end
                ST_READMISS: begin
                    if (mem_ack_i) begin
                        state        <= ST_REFILL;
                        mem_enable_o <= 1'b0;
                        refill_o     <= 1'b1;
                    end
                end
                ST_REFILL: begin
                    state    <= ST_IDLE;
                    refill_o <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    mem_enable_o <= 1'b0;
                    mem_write_o  <= 1'b0;
                    victim_sel_o <= 1'b0;
                    refill_o     <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_PERF_EN
    sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (miss),
        .clear (1'b0),
        .count (miss_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (halt_o),
        .clear (1'b0),
        .count (stall_cnt_o)
    );
`else
    assign miss_cnt_o  = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl: a driver issues hits and misses with
// random memory latencies and queues expected events; a monitor checks them.
module tb_dcache_miss_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req_i, hit_i, dirty_i, mem_ack_i;
    logic             halt_o, mem_enable_o, mem_write_o, victim_sel_o, refill_o;
    logic [CNT_W-1:0] miss_cnt_o, stall_cnt_o;

    dcache_miss_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .hit_i        (hit_i),
        .dirty_i      (dirty_i),
        .mem_ack_i    (mem_ack_i),
        .halt_o       (halt_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .victim_sel_o (victim_sel_o),
        .refill_o     (refill_o),
        .miss_cnt_o   (miss_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int cyc;
        bit wr;
        bit vs;
    } phase_t;

    int     errors = 0;
    int     checks = 0;
    int     cyc    = 0;
    int     exp_halt_q[$];
    phase_t exp_phase_q[$];
    int     exp_refill_q[$];
    int     miss_model  = 0;
    int     stall_model = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: halt run lengths, memory request phases and refill strobes.
    int halt_run = 0;
    bit prev_en  = 1'b0;
    bit prev_ack = 1'b0;
    always @(negedge clk_i) begin
        phase_t p;
        if (halt_o) begin
            halt_run++;
        end else if (halt_run > 0) begin
            if (exp_halt_q.size() == 0) check("halt_unexpected", halt_run, 0);
            else check("halt_len", halt_run, exp_halt_q.pop_front());
            halt_run = 0;
        end
        if (mem_enable_o && (!prev_en || prev_ack)) begin
            if (exp_phase_q.size() == 0) begin
                check("phase_unexpected", int'(mem_enable_o), 0);
            end else begin
                p = exp_phase_q.pop_front();
                check("phase_cycle", cyc, p.cyc);
                check("phase_write", int'(mem_write_o), int'(p.wr));
                check("phase_victim", int'(victim_sel_o), int'(p.vs));
            end
        end
        if (refill_o) begin
            if (exp_refill_q.size() == 0) check("refill_spurious", int'(refill_o), 0);
            else check("refill_cycle", cyc, exp_refill_q.pop_front());
        end
        prev_en  = mem_enable_o;
        prev_ack = mem_ack_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_counters(input string tag);
`ifdef DCACHE_PERF_EN
        check({tag, "_miss_cnt"}, int'(miss_cnt_o), sat(miss_model));
        check({tag, "_stall_cnt"}, int'(stall_cnt_o), sat(stall_model));
`else
        check({tag, "_miss_cnt"}, int'(miss_cnt_o), 0);
        check({tag, "_stall_cnt"}, int'(stall_cnt_o), 0);
`endif
    endtask

    // Hit / idle traffic with random spurious acks, which must change nothing.
    task automatic do_hits(input int n);
        for (int i = 0; i < n; i++) begin
            req_i     = ($urandom_range(0, 3) != 0);
            hit_i     = req_i ? 1'b1 : 1'($urandom);
            dirty_i   = 1'($urandom);
            mem_ack_i = ($urandom_range(0, 3) == 0);
            tick();
        end
        mem_ack_i = 1'b0;
    endtask

    // Miss: detect cycle 0; write-back ack at cycle d1 (dirty only), fetch ack
    // d2 (dirty) or d1 (clean) cycles later, refill next, then IDLE with a hit.
    task automatic do_miss(input bit is_dirty, input int d1, input int d2, input bit refill_ack);
        int c0, total;
        phase_t p;
        c0    = cyc;
        total = is_dirty ? d1 + d2 : d1;
        exp_halt_q.push_back(total + 2);
        exp_refill_q.push_back(c0 + total + 1);
        p.cyc = c0 + 1; p.wr = is_dirty; p.vs = is_dirty;
        exp_phase_q.push_back(p);
        if (is_dirty) begin
            p.cyc = c0 + d1 + 1; p.wr = 1'b0; p.vs = 1'b0;
            exp_phase_q.push_back(p);
        end
        miss_model++;
        stall_model += total + 2;

        req_i = 1'b1; hit_i = 1'b0; dirty_i = is_dirty; mem_ack_i = 1'b0;
        for (int t = 1; t <= total + 1; t++) begin
            tick();
            req_i     = 1'($urandom);
            hit_i     = 1'($urandom);
            dirty_i   = 1'($urandom);
            mem_ack_i = (t == d1) || (is_dirty && t == total) || (refill_ack && t == total + 1);
        end
        tick();
        req_i = 1'b1; hit_i = 1'b1; dirty_i = 1'($urandom); mem_ack_i = 1'b0;
        tick();
    endtask

    // Clean miss with a long fetch, reset at cycle k while the fetch is pending.
    task automatic do_reset_abort(input int k);
        phase_t p;
        p.cyc = cyc + 1; p.wr = 1'b0; p.vs = 1'b0;
        exp_phase_q.push_back(p);
        exp_halt_q.push_back(k);
        req_i = 1'b1; hit_i = 1'b0; dirty_i = 1'b0; mem_ack_i = 1'b0;
        for (int t = 1; t < k; t++) tick();
        tick();
        rst_i = 1'b0; hit_i = 1'b1;
        #1;
        check("rst_mem_enable", int'(mem_enable_o), 0);
        check("rst_refill", int'(refill_o), 0);
        check("rst_halt", int'(halt_o), 0);
        miss_model  = 0;
        stall_model = 0;
        check_counters("rst");
        tick();
        rst_i = 1'b1;
        tick();
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        do_hits(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; req_i = 1'b0; hit_i = 1'b0; dirty_i = 1'b0; mem_ack_i = 1'b0;
        #1;
        check("reset_halt", int'(halt_o), 0);
        check("reset_mem_enable", int'(mem_enable_o), 0);
        check("reset_mem_write", int'(mem_write_o), 0);
        check("reset_victim_sel", int'(victim_sel_o), 0);
        check("reset_refill", int'(refill_o), 0);
        check_counters("reset");
        tick(); tick();
        rst_i = 1'b1;

        do_hits(10);
        check_counters("hits");

        do_miss(1'b0, 3, 0, 1'b0);
        check_counters("clean");

        do_miss(1'b1, 2, 2, 1'b1);
        check_counters("dirty");

        do_reset_abort(3);
        do_hits(3);
        check_counters("post_reset");

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_hits($urandom_range(1, 5));
            end else begin
                do_miss(1'($urandom), $urandom_range(1, 4), $urandom_range(1, 4),
                        1'($urandom));
            end
            check_counters("rand");
        end

        tick(); tick(); tick();
        check("halt_q_empty", exp_halt_q.size(), 0);
        check("phase_q_empty", exp_phase_q.size(), 0);
        check("refill_q_empty", exp_refill_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
